// File: rtl/pipe_ctrl_if.sv
// Pipeline-control handshake bundle shared between the execute/bus side
// (master: raises redirect and hold requests) and pipe_ctrl (slave: turns
// them into hold/stall/redirect controls for the front end).
interface pipe_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        stall_req_i;

  logic [2:0]  hold_flag_o;
  logic        stall_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, stall_req_i,
    input  hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o,
           stall_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, stall_req_i,
    output hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o,
           stall_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
// Arbitrates redirect (jump) > multi-cycle hold > load-use stall, drives the
// front-end hold level, registers the redirect for the PC, and watches for
// holds that last too long.
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// stall/flush performance counters; otherwise both counter ports read 0.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,   // Hold_Id cycles per redirect, 1..3
  parameter int unsigned STALL_TIMEOUT = 255  // HOLD cycles before watchdog pulse, 1..255
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WDOG_LIMIT = 8'(STALL_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        jump_flag_q, jump_flag_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic        timeout_q, timeout_d;

  logic        hold_any;
  logic [2:0]  hold_flag;
  logic        stall_flag;

  // Combinational hold level and stall gate; reset forces both quiet.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hold_any  = bus.hold_ex_i | bus.hold_bus_i;
    hold_flag = HOLD_NONE;
    if (rst)                    hold_flag = HOLD_NONE;
    else if (bus.jump_flag_i)   hold_flag = HOLD_ID;
    else if (state_q == ST_FLUSH) hold_flag = HOLD_ID;
    else if (hold_any)          hold_flag = HOLD_PC;
    // A flushing front end must never also be frozen.
    stall_flag = bus.stall_req_i & ~rst & (hold_flag < HOLD_IF);
  end

  // Next-state logic: jump wins in every state, then FLUSH countdown, then hold.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wdog_d      = wdog_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    timeout_d   = 1'b0;

    if (bus.jump_flag_i) begin
      // A jump during FLUSH simply reloads the counter: no gap cycle.
      jump_flag_d = 1'b1;
      jump_addr_d = bus.jump_addr_i;
      flush_cnt_d = FLUSH_LOAD;
      state_d     = (FLUSH_LOAD != 2'd0) ? ST_FLUSH : ST_IDLE;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q <= 2'd1) begin
            flush_cnt_d = 2'd0;
            state_d     = hold_any ? ST_HOLD : ST_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
        default: state_d = hold_any ? ST_HOLD : ST_IDLE;
      endcase
    end

    // Watchdog holds the number of the current HOLD-state cycle (1 on the
    // first), so the registered pulse lands on cycle STALL_TIMEOUT of HOLD.
    // Saturation at 255 keeps it from matching a second time.
    if (state_d == ST_HOLD) begin
      if (state_q != ST_HOLD)   wdog_d = 8'd1;
      else if (wdog_q != 8'hFF) wdog_d = wdog_q + 8'd1;
      timeout_d = (wdog_d == WDOG_LIMIT) && (wdog_d != wdog_q);
    end else begin
      wdog_d = 8'd0;
    end
  end

  // FSM and registered outputs with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 2'd0;
      wdog_q      <= 8'd0;
      jump_flag_q <= 1'b0;
      jump_addr_q <= 32'h0000_0000;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wdog_q      <= wdog_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.hold_flag_o     = hold_flag;
  assign bus.stall_flag_o    = stall_flag;
  assign bus.jump_flag_o     = jump_flag_q;
  assign bus.jump_addr_o     = jump_addr_q;
  assign bus.stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters: stalled/held cycles and redirects.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((stall_flag || hold_flag == HOLD_PC) && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
    if (bus.jump_flag_i && perf_flush_q != 32'hFFFF_FFFF)
      perf_flush_d = perf_flush_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.stall_cnt_o = perf_stall_q;
  assign bus.flush_cnt_o = perf_flush_q;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: table of single-cycle vectors, redirect
// scoreboard, and hand-written multi-cycle sequences (watchdog, reset in
// FLUSH, performance counters, FLUSH_CYCLES=1 variant).
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl_if bus2 ();

  pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.jump_flag_i = bus.jump_flag_i;
  assign bus2.jump_addr_i = bus.jump_addr_i;
  assign bus2.hold_ex_i   = bus.hold_ex_i;
  assign bus2.hold_bus_i  = bus.hold_bus_i;
  assign bus2.stall_req_i = bus.stall_req_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        j;
    logic [31:0] a;
    logic        ex;
    logic        bs;
    logic        st;
    logic [2:0]  eh;
    logic        es;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mkv(int j, int a, int ex, int bs, int st, int eh, int es);
    vec_t v;
    v.j = 1'(j); v.a = 32'(a); v.ex = 1'(ex); v.bs = 1'(bs); v.st = 1'(st);
    v.eh = 3'(eh); v.es = 1'(es);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic [31:0] a,
                       input logic ex, input logic bs, input logic st);
    sb_t e;
    rst             = r;
    bus.jump_flag_i = j;
    bus.jump_addr_i = a;
    bus.hold_ex_i   = ex;
    bus.hold_bus_i  = bs;
    bus.stall_req_i = st;
    if (j && !r) begin
      e.cyc  = cyc + 1;
      e.addr = a;
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect scoreboard: each accepted jump must appear on jump_flag_o with
  // its address exactly one cycle later, and nowhere else.
  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      check("jump_missing_at", 32'(cyc), 32'(sb_q[0].cyc));
      void'(sb_q.pop_front());
    end
    if (bus.jump_flag_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("jump_unexpected", {31'b0, bus.jump_flag_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("jump_cycle", 32'(cyc), 32'(e.cyc));
        check("jump_addr", bus.jump_addr_o, e.addr);
      end
    end
  end

  initial begin
    int pulses;
    int pulse_at;
    int bad;
    logic [13:0] got2;

    //            j  addr   ex bs st eh es
    tbl[0]  = mkv(0, 'h000, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 'h000, 0, 0, 1, 0, 1);
    tbl[2]  = mkv(0, 'h000, 1, 0, 0, 1, 0);
    tbl[3]  = mkv(0, 'h000, 0, 1, 1, 1, 1);
    tbl[4]  = mkv(0, 'h000, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 'h100, 0, 0, 0, 3, 0);
    tbl[6]  = mkv(0, 'h000, 0, 0, 0, 3, 0);
    tbl[7]  = mkv(0, 'h000, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(1, 'h200, 0, 0, 1, 3, 0);
    tbl[9]  = mkv(0, 'h000, 0, 0, 1, 3, 0);
    tbl[10] = mkv(0, 'h000, 0, 0, 1, 0, 1);
    tbl[11] = mkv(1, 'h300, 1, 0, 0, 3, 0);
    tbl[12] = mkv(0, 'h000, 1, 0, 0, 3, 0);
    tbl[13] = mkv(0, 'h000, 1, 0, 0, 1, 0);
    tbl[14] = mkv(1, 'h400, 1, 0, 0, 3, 0);
    tbl[15] = mkv(1, 'h500, 0, 0, 0, 3, 0);
    tbl[16] = mkv(0, 'h000, 0, 0, 0, 3, 0);
    tbl[17] = mkv(0, 'h000, 0, 0, 0, 0, 0);

    // Reset with every request asserted: outputs stay quiet.
    drive(1, 1, 32'hDEAD_BEEF, 1, 1, 1);
    @(negedge clk);
    check("rst0_hold", 32'(bus.hold_flag_o), 32'd0);
    check("rst0_stall", 32'(bus.stall_flag_o), 32'd0);
    tick();
    drive(1, 1, 32'hDEAD_BEEF, 1, 1, 1);
    @(negedge clk);
    check("rst1_hold", 32'(bus.hold_flag_o), 32'd0);
    check("rst1_stall", 32'(bus.stall_flag_o), 32'd0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_jump", 32'(bus.jump_flag_o), 32'd0);
    check("post_rst_addr", bus.jump_addr_o, 32'd0);
    check("post_rst_timeout", 32'(bus.stall_timeout_o), 32'd0);
    check("post_rst_stall_cnt", bus.stall_cnt_o, 32'd0);
    check("post_rst_flush_cnt", bus.flush_cnt_o, 32'd0);
    tick();

    // Single-cycle vectors: priorities, FLUSH length, jump restart in FLUSH.
    for (int i = 0; i < 18; i++) begin
      drive(0, tbl[i].j, tbl[i].a, tbl[i].ex, tbl[i].bs, tbl[i].st);
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), 32'(bus.hold_flag_o), 32'(tbl[i].eh));
      check($sformatf("vec%0d_stall", i), 32'(bus.stall_flag_o), 32'(tbl[i].es));
      tick();
    end
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("tbl_stall_cnt", bus.stall_cnt_o, PERF_ON ? 32'd5 : 32'd0);
    check("tbl_flush_cnt", bus.flush_cnt_o, PERF_ON ? 32'd5 : 32'd0);
    tick();

    // Long hold: Hold_Pc throughout, one watchdog pulse on HOLD cycle 255.
    pulses = 0; pulse_at = -1; bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 32'h0, 1, 0, 0);
      @(negedge clk);
      if (bus.hold_flag_o !== 3'd1) bad++;
      if (bus.stall_timeout_o === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
      tick();
    end
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("wd_release_hold", 32'(bus.hold_flag_o), 32'd0);
    check("wd_release_timeout", 32'(bus.stall_timeout_o), 32'd0);
    tick();
    check("wd_hold_flag_bad_cycles", 32'(bad), 32'd0);
    check("wd_pulse_count", 32'(pulses), 32'd1);
    check("wd_pulse_cycle", 32'(pulse_at), 32'd255);

    // Short-timeout instance: watchdog re-arms after HOLD is left.
    drive(0, 0, 32'h0, 0, 0, 0);
    tick();
    got2 = '0;
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 32'h0, (i != 6 && i < 13), 0, 0);
      @(negedge clk);
      got2[i] = bus2.stall_timeout_o;
      tick();
    end
    check("wd2_pulse_mask", 32'(got2), 32'h408);

    // FLUSH_CYCLES=1: Hold_Id only on the jump cycle.
    drive(0, 1, 32'h800, 0, 0, 0);
    @(negedge clk);
    check("fc1_jump_hold", 32'(bus2.hold_flag_o), 32'd3);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("fc1_next_hold", 32'(bus2.hold_flag_o), 32'd0);
    check("fc1_jump_o", 32'(bus2.jump_flag_o), 32'd1);
    check("fc1_addr_o", bus2.jump_addr_o, 32'h800);
    check("fc2_flush_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("fc1_jump_o_clear", 32'(bus2.jump_flag_o), 32'd0);
    check("fc2_idle_hold", 32'(bus.hold_flag_o), 32'd0);
    tick();

    // Reset in the middle of FLUSH (counter=1).
    drive(0, 1, 32'h700, 0, 0, 0);
    @(negedge clk);
    check("rf_jump_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    drive(1, 0, 32'h0, 1, 0, 1);
    @(negedge clk);
    check("rf_rst_hold", 32'(bus.hold_flag_o), 32'd0);
    check("rf_rst_stall", 32'(bus.stall_flag_o), 32'd0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("rf_after_hold", 32'(bus.hold_flag_o), 32'd0);
    check("rf_after_jump", 32'(bus.jump_flag_o), 32'd0);
    check("rf_after_addr", bus.jump_addr_o, 32'd0);
    check("rf_after_timeout", 32'(bus.stall_timeout_o), 32'd0);
    check("rf_after_stall_cnt", bus.stall_cnt_o, 32'd0);
    check("rf_after_flush_cnt", bus.flush_cnt_o, 32'd0);
    tick();

    // Performance counters: 3 jumps then 5 stall cycles.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'(32'h10 * (k + 1)), 0, 0, 0);
      tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 32'h0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("perf_flush_cnt", bus.flush_cnt_o, PERF_ON ? 32'd3 : 32'd0);
    check("perf_stall_cnt", bus.stall_cnt_o, PERF_ON ? 32'd5 : 32'd0);
    tick();
    tick();
    check("sb_pending", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
